pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core. Merges stall requests from ID, EX (multi-cycle mult/div) and MEM (bus wait) into the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. Sequences exception flushes over a programmable hold window and supplies the redirect PC. Runs a stall watchdog that flags a hung pipeline.

Parameters:
FLUSH_CYCLES, 1, cycles flush is held per exception (1..15)
STALL_TIMEOUT, 1024, consecutive stalled cycles before watchdog fires (2..65535)
INT_VECTOR, 32'h00000020, redirect PC for interrupt
EXC_VECTOR, 32'h00000040, redirect PC for all other non-ERET exceptions

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high (`RstEnable)
stallreq_from_id  input  1  ID load-use / operand hazard
stallreq_from_ex  input  1  EX multi-cycle op busy
stallreq_from_mem  input  1  MEM bus access pending
excepttype_i  input  32  exception type from MEM; 0 = none
cp0_epc_i  input  32  EPC for ERET return
stall  output  6  [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1 = `Stop
flush  output  1  flush all pipeline registers
new_pc  output  32  redirect target, valid while flush=1
stall_timeout_o  output  1  one-cycle watchdog pulse

Behaviour:
- Reset (rst=1 at posedge): state=RUN, flush counter=0, watchdog counter=0. While rst is high, all outputs are forced to 0 combinationally.
- stall/flush/new_pc are combinational from inputs and state, so pipeline registers see them in the same cycle. stall_timeout_o is registered.
- States: RUN, FLUSH.
- RUN, excepttype_i != 0: flush=1, stall=6'b000000, new_pc by code: 0x1 -> INT_VECTOR; 0xe (ERET) -> cp0_epc_i; 0x8, 0xa, 0xd, 0xc -> EXC_VECTOR; any other nonzero code -> EXC_VECTOR. If FLUSH_CYCLES>1, load counter=FLUSH_CYCLES-1 and go to FLUSH.
- RUN, no exception: priority mem > ex > id. mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; none -> 6'b000000. flush=0, new_pc=0.
- FLUSH: flush=1. new_pc holds the value latched in the entry cycle. stall=0. Stall requests and new exceptions are ignored. Counter decrements each cycle; on the cycle counter==1, next state is RUN.
- Exception beats stall in the same cycle; flush wins.
- Watchdog (RUN only): increments each cycle stall!=0 and clears when stall==0, on flush, or in FLUSH. When the count reaches STALL_TIMEOUT-1 with stall still nonzero, stall_timeout_o pulses 1 on the next cycle. The counter then clears and restarts; stall is not altered.
- Reset mid-FLUSH aborts the flush; on the next cycle the block is in RUN with flush=0.

Optional Feature:
STALL_PERF_EN. Defined: adds outputs perf_id_o, perf_ex_o, perf_mem_o (32-bit each), counting cycles where that source is the winning stall source. Counters saturate at 32'hFFFFFFFF and reset to 0 on rst. Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Stall encodings (STALL_NONE/ID/EX/MEM), exception codes, FSM state codes and Stop/NoStop go in the shared defines.v include.
- One sub-module: stall_watchdog (counter, threshold compare, registered pulse), parameterised by STALL_TIMEOUT.

Test Plan:
- rst=1 with stallreq_from_mem=1 and excepttype_i=1 -> stall=0, flush=0, new_pc=0. Release rst -> next cycle stall=6'b011111.
- stallreq_from_id=1 and stallreq_from_ex=1 together -> stall=6'b001111. Drop ex -> 6'b000111. Drop id -> 6'b000000.
- excepttype_i=32'he, cp0_epc_i=32'h00400010, stallreq_from_mem=1 -> flush=1, new_pc=32'h00400010, stall=0 in the same cycle.
- FLUSH_CYCLES=3, excepttype_i=1 for one cycle, then 8 with a stall request -> flush=1 for exactly 3 cycles, new_pc=32'h20 throughout, stall=0. Back in RUN, stall follows the request.
- STALL_TIMEOUT=4, hold stallreq_from_ex=1 -> stall_timeout_o pulses once after 4 stalled cycles, again after 8. A one-cycle gap in stall restarts the count.
- STALL_PERF_EN, 5 cycles mem+id requests then 2 cycles id only -> perf_mem_o=5, perf_id_o=2, perf_ex_o=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states, stall vector
// encodings, MEM-stage exception codes and the redirect decode helper.
package pipeline_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // stall vector bit order: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INV     = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  // Redirect target for a nonzero exception code; unknown codes take the
  // general exception vector.
  function automatic logic [31:0] redirect_pc(input logic [31:0] code,
                                              input logic [31:0] epc,
                                              input logic [31:0] int_vec,
                                              input logic [31:0] exc_vec);
    logic [31:0] target;
    case (code)
      EXC_INT:                                target = int_vec;
      EXC_ERET:                               target = epc;
      EXC_SYSCALL, EXC_INV, EXC_OV, EXC_TRAP: target = exc_vec;
      default:                                target = exc_vec;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and emits a registered
// one-cycle pulse when STALL_TIMEOUT of them have elapsed, then restarts.
module pipeline_ctrl_stall_watchdog #(
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic timeout
);

  localparam logic [15:0] LAST = 16'(STALL_TIMEOUT - 1);

  logic [15:0] count_q;
  logic        pulse_q;

  // Count while active; any idle cycle restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'd0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (!active) begin
        count_q <= 16'd0;
      end else if (count_q == LAST) begin
        count_q <= 16'd0;
        pulse_q <= 1'b1;
      end else begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign timeout = pulse_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences exception
// flushes with a held redirect PC, and hosts the stall watchdog.
// Optional build macro STALL_PERF_EN adds per-source stall cycle counters.
//
// state    | meaning
// ST_RUN   | normal operation, stalls honoured, exceptions accepted
// ST_FLUSH | holding flush after an exception, inputs ignored
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int          FLUSH_CYCLES  = 1,
  parameter int          STALL_TIMEOUT = 1024,
  parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
`ifdef STALL_PERF_EN
  output logic [31:0] perf_id_o,
  output logic [31:0] perf_ex_o,
  output logic [31:0] perf_mem_o,
`endif
  output logic        stall_timeout_o
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [5:0]  stall_raw;
  logic        flush_raw;
  logic [31:0] pc_raw;
  logic        win_id, win_ex, win_mem;
  logic        wd_pulse;
  logic [31:0] exc_pc;

  assign exc_pc = redirect_pc(excepttype_i, cp0_epc_i, INT_VECTOR, EXC_VECTOR);

  // Next-state and combinational pipeline controls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    stall_raw = STALL_NONE;
    flush_raw = 1'b0;
    pc_raw    = 32'd0;
    win_id    = 1'b0;
    win_ex    = 1'b0;
    win_mem   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (excepttype_i != EXC_NONE) begin
          flush_raw = 1'b1;
          pc_raw    = exc_pc;
          pc_d      = exc_pc;
          if (FLUSH_CYCLES > 1) begin
            cnt_d   = 4'(FLUSH_CYCLES - 1);
            state_d = ST_FLUSH;
          end
        end else if (stallreq_from_mem) begin
          stall_raw = STALL_MEM;
          win_mem   = 1'b1;
        end else if (stallreq_from_ex) begin
          stall_raw = STALL_EX;
          win_ex    = 1'b1;
        end else if (stallreq_from_id) begin
          stall_raw = STALL_ID;
          win_id    = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush_raw = 1'b1;
        pc_raw    = pc_q;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, flush counter and latched redirect PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  pipeline_ctrl_stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .active (stall_raw != STALL_NONE),
    .timeout(wd_pulse)
  );

  assign stall           = rst ? STALL_NONE : stall_raw;
  assign flush           = flush_raw & ~rst;
  assign new_pc          = rst ? 32'd0 : pc_raw;
  assign stall_timeout_o = wd_pulse & ~rst;

`ifdef STALL_PERF_EN
  logic [31:0] perf_id_q, perf_ex_q, perf_mem_q;

  // Saturating per-source counts of cycles where that source won the stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_id_q  <= 32'd0;
      perf_ex_q  <= 32'd0;
      perf_mem_q <= 32'd0;
    end else begin
      if (win_id  && perf_id_q  != 32'hFFFF_FFFF) perf_id_q  <= perf_id_q  + 32'd1;
      if (win_ex  && perf_ex_q  != 32'hFFFF_FFFF) perf_ex_q  <= perf_ex_q  + 32'd1;
      if (win_mem && perf_mem_q != 32'hFFFF_FFFF) perf_mem_q <= perf_mem_q + 32'd1;
    end
  end

  assign perf_id_o  = rst ? 32'd0 : perf_id_q;
  assign perf_ex_o  = rst ? 32'd0 : perf_ex_q;
  assign perf_mem_o = rst ? 32'd0 : perf_mem_q;
`endif

endmodule
